// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
// Defines the owner encoding used by the grant decision and the state register.
// Also defines the default burst limit.
package mem_arbiter_pkg;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_burst_pick.sv
// Round-robin grant decision with a bounded burst for two requesters.
// Latency: purely combinational, so the grant is valid in the request cycle.
// Backpressure: the losing side simply sees no grant and must keep its request held.
module rr_burst_pick
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int BURST_BITS = 3
) (
    input  logic                  i_a_req,
    input  logic                  i_b_req,
    input  owner_t                i_last_owner,
    input  logic [BURST_BITS-1:0] i_burst_cnt,
    output logic                  o_a_gnt,
    output logic                  o_b_gnt
);

    logic w_keep;

    // Pick a winner. A zero count means no burst is in progress, so priority passes
    // to the side that did not own the RAM last. This is what gives A first go after reset.
    always_comb begin
        o_a_gnt = 1'b0;
        o_b_gnt = 1'b0;
        w_keep  = (i_burst_cnt != '0) && (i_burst_cnt < BURST_BITS'(MAX_BURST));
        if (i_a_req && !i_b_req) begin
            o_a_gnt = 1'b1;
        end else if (i_b_req && !i_a_req) begin
            o_b_gnt = 1'b1;
        end else if (i_a_req && i_b_req) begin
            if ((i_last_owner == OWNER_A) == w_keep) begin
                o_a_gnt = 1'b1;
            end else begin
                o_b_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port clocked RAM between requester A and requester B.
// Latency: the grant is combinational, and read data is valid one cycle after the grant.
// Backpressure: a requester holds its request until it sees gnt, and withdrawing before gnt has no effect.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADR_BITS   = 16,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int BURST_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [ADR_BITS-1:0] a_adr,
    input  logic [WIDTH-1:0]    a_wdata,
    output logic                a_gnt,
    output logic                a_rvalid,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADR_BITS-1:0] b_adr,
    input  logic [WIDTH-1:0]    b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [WIDTH-1:0]    rd_data,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_dataFromMem
);

    owner_t                r_last_owner;
    logic [BURST_BITS-1:0] r_burst_cnt;
    logic                  r_rv_a;
    logic                  r_rv_b;

    logic                  w_pick_a;
    logic                  w_pick_b;
    logic                  w_a_gnt;
    logic                  w_b_gnt;
    logic                  w_any;
    owner_t                w_winner;

    rr_burst_pick #(
        .MAX_BURST  (MAX_BURST),
        .BURST_BITS (BURST_BITS)
    ) u_pick (
        .i_a_req      (a_req),
        .i_b_req      (b_req),
        .i_last_owner (r_last_owner),
        .i_burst_cnt  (r_burst_cnt),
        .o_a_gnt      (w_pick_a),
        .o_b_gnt      (w_pick_b)
    );

    // Grants are suppressed while reset is held, so no RAM access can start then.
    assign w_a_gnt  = w_pick_a & ~reset;
    assign w_b_gnt  = w_pick_b & ~reset;
    assign w_any    = w_a_gnt | w_b_gnt;
    assign w_winner = w_b_gnt ? OWNER_B : OWNER_A;

    assign a_gnt     = w_a_gnt;
    assign b_gnt     = w_b_gnt;
    assign mem_en    = w_any;
    assign mem_we    = w_b_gnt ? b_we : (w_a_gnt & a_we);
    assign mem_adr   = w_b_gnt ? b_adr : a_adr;
    assign mem_wdata = w_b_gnt ? b_wdata : a_wdata;
    assign a_rvalid  = r_rv_a;
    assign b_rvalid  = r_rv_b;
    assign rd_data   = mem_dataFromMem;

    // Track the burst owner and its length, and tag each granted read for next-cycle return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWNER_B;
            r_burst_cnt  <= '0;
            r_rv_a       <= 1'b0;
            r_rv_b       <= 1'b0;
        end else begin
            r_rv_a <= w_a_gnt & ~a_we;
            r_rv_b <= w_b_gnt & ~b_we;
            if (!w_any) begin
                r_burst_cnt <= '0;
            end else if (w_winner == r_last_owner) begin
                if (r_burst_cnt != '1) begin
                    r_burst_cnt <= r_burst_cnt + BURST_BITS'(1);
                end
            end else begin
                r_burst_cnt  <= BURST_BITS'(1);
                r_last_owner <= w_winner;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MAX_BURST=4 and one with MAX_BURST=1.
// Each instance has its own read-first RAM model, and both instances share the same stimulus.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_adr, a_wdata, b_adr, b_wdata;

    logic        a_gnt4, b_gnt4, a_rvalid4, b_rvalid4, mem_en4, mem_we4;
    logic [15:0] rd_data4, mem_adr4, mem_wdata4, dout4;
    logic        a_gnt1, b_gnt1, a_rvalid1, b_rvalid1, mem_en1, mem_we1;
    logic [15:0] rd_data1, mem_adr1, mem_wdata1, dout1;

    logic [15:0] ram4 [256];
    logic [15:0] ram1 [256];

    int checks;
    int failures;

    mem_arbiter #(.WIDTH(16), .ADR_BITS(16), .MAX_BURST(4), .BURST_BITS(3)) dut4 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
        .a_gnt(a_gnt4), .a_rvalid(a_rvalid4),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
        .b_gnt(b_gnt4), .b_rvalid(b_rvalid4),
        .rd_data(rd_data4), .mem_en(mem_en4), .mem_we(mem_we4),
        .mem_adr(mem_adr4), .mem_wdata(mem_wdata4), .mem_dataFromMem(dout4)
    );

    mem_arbiter #(.WIDTH(16), .ADR_BITS(16), .MAX_BURST(1), .BURST_BITS(3)) dut1 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rvalid1),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rvalid1),
        .rd_data(rd_data1), .mem_en(mem_en1), .mem_we(mem_we1),
        .mem_adr(mem_adr1), .mem_wdata(mem_wdata1), .mem_dataFromMem(dout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first single-port RAM behind each arbiter.
    always @(posedge clk) begin
        if (mem_en4) begin
            if (mem_we4) ram4[mem_adr4[7:0]] <= mem_wdata4;
            dout4 <= ram4[mem_adr4[7:0]];
        end
        if (mem_en1) begin
            if (mem_we1) ram1[mem_adr1[7:0]] <= mem_wdata1;
            dout1 <= ram1[mem_adr1[7:0]];
        end
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%04h exp=%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [15:0] adr, input logic [15:0] wd);
        a_req = req; a_we = we; a_adr = adr; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [15:0] adr, input logic [15:0] wd);
        b_req = req; b_we = we; b_adr = adr; b_wdata = wd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held with both sides requesting: nothing may be granted.
        reset = 1'b1;
        set_a(1'b1, 1'b1, 16'd0, 16'hFFFF);
        set_b(1'b1, 1'b1, 16'd0, 16'hFFFF);
        #2;
        chk1("rst_a_gnt", a_gnt4, 1'b0);
        chk1("rst_b_gnt", b_gnt4, 1'b0);
        chk1("rst_mem_en", mem_en4, 1'b0);
        chk1("rst_mem_we", mem_we4, 1'b0);
        chk1("rst_a_rvalid", a_rvalid4, 1'b0);
        chk1("rst_b_rvalid", b_rvalid4, 1'b0);
        chk1("rst_mem_en1", mem_en1, 1'b0);
        tick();
        reset = 1'b0;
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        set_b(1'b0, 1'b0, 16'd0, 16'd0);
        #1;

        // Lone A read: B writes 1234 to adr 5, then A reads it back.
        set_b(1'b1, 1'b1, 16'd5, 16'h1234);
        #1;
        chk1("t1_b_gnt", b_gnt4, 1'b1);
        chk1("t1_a_gnt_idle", a_gnt4, 1'b0);
        chk1("t1_mem_we", mem_we4, 1'b1);
        chk16("t1_mem_adr", mem_adr4, 16'd5);
        tick();
        set_b(1'b0, 1'b0, 16'd0, 16'd0);
        set_a(1'b1, 1'b0, 16'd5, 16'd0);
        #1;
        chk1("t1_a_gnt", a_gnt4, 1'b1);
        chk1("t1_mem_en", mem_en4, 1'b1);
        chk1("t1_mem_we_rd", mem_we4, 1'b0);
        chk1("t1_b_rvalid_wr", b_rvalid4, 1'b0);
        tick();
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        #1;
        chk1("t1_a_rvalid", a_rvalid4, 1'b1);
        chk16("t1_rd_data", rd_data4, 16'h1234);
        chk1("t1_b_rvalid", b_rvalid4, 1'b0);
        chk1("t1_mem_en_idle", mem_en4, 1'b0);
        tick();
        #1;
        chk1("t1_a_rvalid_clr", a_rvalid4, 1'b0);

        // Preload words used later (single requester, so each access is granted).
        set_a(1'b1, 1'b1, 16'd7, 16'h00AA); tick();
        set_a(1'b1, 1'b1, 16'd1, 16'hA001); tick();
        set_a(1'b1, 1'b1, 16'd9, 16'h1111); tick();
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        set_b(1'b1, 1'b1, 16'd2, 16'hB002); tick();
        set_b(1'b0, 1'b0, 16'd0, 16'd0);

        // Back-to-back read then write to the same address: the read returns the old value.
        set_a(1'b1, 1'b0, 16'd7, 16'd0);
        #1;
        chk1("t2_rd_gnt", a_gnt4, 1'b1);
        tick();
        set_a(1'b1, 1'b1, 16'd7, 16'h00BB);
        #1;
        chk1("t2_wr_gnt", a_gnt4, 1'b1);
        chk1("t2_wr_mem_we", mem_we4, 1'b1);
        chk1("t2_rvalid", a_rvalid4, 1'b1);
        chk16("t2_old_data", rd_data4, 16'h00AA);
        tick();
        set_a(1'b1, 1'b0, 16'd7, 16'd0);
        #1;
        chk1("t2_no_rvalid_wr", a_rvalid4, 1'b0);
        tick();
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        #1;
        chk1("t2_rvalid2", a_rvalid4, 1'b1);
        chk16("t2_new_data", rd_data4, 16'h00BB);
        tick();

        // Withdrawal: B asks to write while A is inside its burst, then gives up.
        set_a(1'b1, 1'b0, 16'd1, 16'd0);
        #1;
        chk1("t3_a_gnt0", a_gnt4, 1'b1);
        tick();
        set_b(1'b1, 1'b1, 16'd9, 16'hDEAD);
        #1;
        chk1("t3_b_gnt1", b_gnt4, 1'b0);
        chk1("t3_mem_we1", mem_we4, 1'b0);
        chk1("t3_b_rvalid1", b_rvalid4, 1'b0);
        tick();
        #1;
        chk1("t3_b_gnt2", b_gnt4, 1'b0);
        chk1("t3_mem_we2", mem_we4, 1'b0);
        tick();
        set_b(1'b0, 1'b0, 16'd0, 16'd0);
        #1;
        chk1("t3_a_gnt3", a_gnt4, 1'b1);
        chk1("t3_b_rvalid3", b_rvalid4, 1'b0);
        tick();
        set_a(1'b1, 1'b0, 16'd9, 16'd0);
        tick();
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        #1;
        chk1("t3_a_rvalid", a_rvalid4, 1'b1);
        chk16("t3_adr9_kept", rd_data4, 16'h1111);
        chk1("t3_b_rvalid4", b_rvalid4, 1'b0);
        tick();

        // Contention from reset: both sides read every cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_a(1'b1, 1'b0, 16'd1, 16'd0);
        set_b(1'b1, 1'b0, 16'd2, 16'd0);
        for (int k = 0; k < 12; k++) begin
            logic exp4_a;
            logic exp1_a;
            logic prev1_a;
            #1;
            exp4_a  = ((k / 4) % 2) == 0;
            exp1_a  = (k % 2) == 0;
            prev1_a = ((k - 1) % 2) == 0;
            chk1($sformatf("t4_b4_a_gnt_c%0d", k), a_gnt4, exp4_a);
            chk1($sformatf("t4_b4_b_gnt_c%0d", k), b_gnt4, ~exp4_a);
            chk1($sformatf("t4_b1_a_gnt_c%0d", k), a_gnt1, exp1_a);
            chk1($sformatf("t4_b1_b_gnt_c%0d", k), b_gnt1, ~exp1_a);
            if (k == 0) begin
                chk1("t4_b1_a_rvalid_c0", a_rvalid1, 1'b0);
                chk1("t4_b1_b_rvalid_c0", b_rvalid1, 1'b0);
            end else begin
                chk1($sformatf("t4_b1_a_rvalid_c%0d", k), a_rvalid1, prev1_a);
                chk1($sformatf("t4_b1_b_rvalid_c%0d", k), b_rvalid1, ~prev1_a);
                chk16($sformatf("t4_b1_rd_data_c%0d", k), rd_data1, prev1_a ? 16'hA001 : 16'hB002);
            end
            tick();
        end
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        set_b(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        // Asynchronous reset arriving while an A read is waiting to return.
        set_a(1'b1, 1'b0, 16'd1, 16'd0);
        #1;
        chk1("t5_a_gnt", a_gnt4, 1'b1);
        tick();
        set_b(1'b1, 1'b0, 16'd2, 16'd0);
        #1;
        chk1("t5_rvalid_pending", a_rvalid4, 1'b1);
        reset = 1'b1;
        #1;
        chk1("t5_rvalid_dropped", a_rvalid4, 1'b0);
        chk1("t5_a_gnt_rst", a_gnt4, 1'b0);
        chk1("t5_b_gnt_rst", b_gnt4, 1'b0);
        chk1("t5_mem_en_rst", mem_en4, 1'b0);
        tick();
        chk1("t5_mem_en_rst2", mem_en4, 1'b0);
        chk1("t5_rvalid_rst2", a_rvalid4, 1'b0);
        reset = 1'b0;
        #1;
        chk1("t5_a_first", a_gnt4, 1'b1);
        chk1("t5_b_waits", b_gnt4, 1'b0);
        tick();
        #1;
        chk1("t5_a_rvalid_after", a_rvalid4, 1'b1);
        chk16("t5_rd_data_after", rd_data4, 16'hA001);
        set_a(1'b0, 1'b0, 16'd0, 16'd0);
        set_b(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
